fp8_pe_seq: RTL and testbench
=============================

# fp8_pe_seq

Operand sequencer directly upstream of the FP8 processing element (PE). Holds up to DEPTH FP8 operand pairs (one kernel window × activation window), then on command clears the PE accumulator, streams the pairs under the PE's ready/valid handshake, waits for MAC completion, reads the result and presents it downstream with a valid/ready handshake. One dot product per command.

## Interface
- DEPTH, 9: max pairs per dot product (3×3 kernel); ≥2
- LEN_W, $clog2(DEPTH+1): width of length field
- ADDR_W, $clog2(DEPTH): buffer address width
- clk  in  1  single clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_wr_en  in  1  write pair into buffer (accepted only in IDLE)
- i_wr_addr  in  ADDR_W  buffer slot
- i_wr_a, i_wr_b  in  8 each  FP8 operands for slot
- i_start  in  1  begin dot product (accepted only in IDLE)
- i_len  in  LEN_W  pairs to use, slots 0..i_len-1; valid 1..DEPTH
- o_busy  out  1  high in any state but IDLE
- o_cmd_err  out  1  one-cycle pulse: i_start rejected for bad length
- o_pe_a, o_pe_b  out  8 each  operands to PE
- o_pe_data_valid  out  1  pair on o_pe_a/b is valid
- o_pe_clear_acc  out  1  one-cycle accumulator clear
- o_pe_read_en  out  1  one-cycle result read acknowledge
- i_pe_ready_for_new  in  1  PE accepts a pair this cycle
- i_pe_mac_done  in  1  PE result valid; held until read_en
- i_pe_c  in  8  PE result
- o_result  out  8  captured FP8 dot product
- o_result_valid  out  1  o_result valid
- i_result_ready  in  1  downstream accepts result

## Operation
- All outputs registered; reset value 0 for every output; FSM → IDLE, counter → 0. Buffer contents not cleared by reset.
- States: IDLE, CLEAR, STREAM, WAIT_DONE, READ, HOLD.
- IDLE: i_wr_en writes {a,b} to slot i_wr_addr (addresses ≥ DEPTH ignored). i_start with 1 ≤ i_len ≤ DEPTH → latch len, idx=0, → CLEAR; otherwise o_cmd_err pulses next cycle, stay IDLE.
- CLEAR: o_pe_clear_acc high one cycle (PE accepts unconditionally) → STREAM.
- STREAM: o_pe_data_valid=1, o_pe_a/b = buf[idx]. Transfer = valid & i_pe_ready_for_new; on transfer idx++. Data held stable while ready low. Transfer of idx=len-1 → WAIT_DONE, valid drops next cycle.
- WAIT_DONE: wait for i_pe_mac_done sampled high → READ.
- READ: o_pe_read_en high one cycle; o_result ← i_pe_c at that edge → HOLD.
- HOLD: o_result_valid=1, o_result stable until i_result_ready sampled high → IDLE.
- i_wr_en and i_start outside IDLE ignored (no error pulse). i_wr_en and i_start in the same IDLE cycle: write lands; stream uses new value.
- i_reset mid-operation: immediate return to IDLE; any partially issued PE sequence abandoned (next command always begins with CLEAR).

## Timing
- i_start sampled at edge 0 → o_busy and o_pe_clear_acc high cycle 1; first o_pe_data_valid cycle 2.
- With ready held high, len L: valid high cycles 2..L+1, one pair per cycle.
- mac_done sampled high at edge k → o_pe_read_en high cycle k+1 → o_result_valid high cycle k+2.
- Minimum IDLE-to-IDLE: L + 5 cycles plus PE latency.
- i_result_ready high on first HOLD cycle → o_result_valid one cycle, o_busy low next cycle; new i_start accepted that cycle.

## Structure
- Shared package fp8_pkg: FP8_W=8 constant, sequencer state enum, FP8 constants used by benches (0x38 = 1.0, 0x40 = 2.0, E4M3).
- One sub-module: fp8_pair_buf — DEPTH×16-bit register file, one synchronous write port, one combinational read port.

## Test plan
- Write slots 0..8 with a=0x38, b=0x40, start len=9, ready always high → clear_acc pulse cycle 1, nine consecutive valid cycles 2..10 with a=0x38/b=0x40, single read_en; o_result equals PE model i_pe_c.
- len=4, ready toggles 1,0,0,1… → exactly 4 transfers, o_pe_a/b stable during every ready-low cycle, idx never skips.
- i_start with len=0 and len=10 → o_cmd_err one pulse each, o_busy stays 0, no PE strobes.
- Hold i_result_ready low 5 cycles in HOLD → o_result/o_result_valid stable 5 cycles; i_start and i_wr_en during busy ignored (buffer unchanged, no restart).
- Assert i_reset during STREAM after 2 of 9 transfers → next cycle all outputs 0, IDLE; fresh start len=3 begins with clear_acc and streams slots 0..2.
- i_wr_en to slot 0 (a=0x40) in same cycle as i_start len=1 → first streamed pair a=0x40.

Source files
------------

// File: rtl/fp8_pkg.sv
// Shared definitions for the FP8 PE operand sequencer and its bench:
// operand width, sequencer state encoding and a few E4M3 constants.
package fp8_pkg;

    localparam int FP8_W = 8;

    // E4M3 reference values
    localparam logic [FP8_W-1:0] FP8_ONE = 8'h38;  // 1.0
    localparam logic [FP8_W-1:0] FP8_TWO = 8'h40;  // 2.0

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_STREAM    = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_READ      = 3'd4,
        ST_HOLD      = 3'd5
    } seq_state_t;

    // A dot-product length is usable when it selects at least one slot
    // and no more slots than the buffer holds.
    function automatic logic len_in_range(input logic [31:0] len, input logic [31:0] depth);
        return (len != 32'd0) && (len <= depth);
    endfunction

endpackage

// File: rtl/fp8_pe_seq_if.sv
// Sequencer <-> processing-element link: operand stream with ready/valid,
// accumulator clear, and result completion/read handshake.
interface fp8_pe_seq_if;
    import fp8_pkg::*;

    logic [FP8_W-1:0] o_pe_a;
    logic [FP8_W-1:0] o_pe_b;
    logic             o_pe_data_valid;
    logic             o_pe_clear_acc;
    logic             o_pe_read_en;
    logic             i_pe_ready_for_new;
    logic             i_pe_mac_done;
    logic [FP8_W-1:0] i_pe_c;

    // Sequencer side
    modport master (
        output o_pe_a, o_pe_b, o_pe_data_valid, o_pe_clear_acc, o_pe_read_en,
        input  i_pe_ready_for_new, i_pe_mac_done, i_pe_c
    );

    // PE side
    modport slave (
        input  o_pe_a, o_pe_b, o_pe_data_valid, o_pe_clear_acc, o_pe_read_en,
        output i_pe_ready_for_new, i_pe_mac_done, i_pe_c
    );

endinterface

// File: rtl/fp8_pair_buf.sv
// Operand pair register file: DEPTH entries of {a, b}, one synchronous
// write port and one combinational read port. Contents survive reset.
module fp8_pair_buf
    import fp8_pkg::*;
#(
    parameter int DEPTH  = 9,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [ADDR_W-1:0]    i_waddr,
    input  logic [2*FP8_W-1:0]   i_wdata,
    input  logic [ADDR_W-1:0]    i_raddr,
    output logic [2*FP8_W-1:0]   o_rdata
);

    logic [2*FP8_W-1:0] r_mem [DEPTH];

    logic w_wr_ok;
    logic w_rd_ok;

    assign w_wr_ok = int'(i_waddr) < DEPTH;
    assign w_rd_ok = int'(i_raddr) < DEPTH;

    // Store a pair; addresses beyond the buffer are dropped
    always_ff @(posedge clk) begin
        if (i_we && w_wr_ok) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = w_rd_ok ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/fp8_pe_seq.sv
// Operand sequencer feeding one FP8 PE: buffers up to DEPTH operand pairs,
// then per command clears the accumulator, streams the pairs, waits for
// the MAC result, reads it and offers it downstream on valid/ready.
module fp8_pe_seq
    import fp8_pkg::*;
#(
    parameter int DEPTH  = 9,
    parameter int LEN_W  = $clog2(DEPTH+1),
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_wr_en,
    input  logic [ADDR_W-1:0]  i_wr_addr,
    input  logic [FP8_W-1:0]   i_wr_a,
    input  logic [FP8_W-1:0]   i_wr_b,
    input  logic               i_start,
    input  logic [LEN_W-1:0]   i_len,
    output logic               o_busy,
    output logic               o_cmd_err,
    fp8_pe_seq_if.master       pe,
    output logic [FP8_W-1:0]   o_result,
    output logic               o_result_valid,
    input  logic               i_result_ready
);

    seq_state_t r_state, w_state_nxt;
    logic [LEN_W-1:0] r_idx, w_idx_nxt;
    logic [LEN_W-1:0] r_len, w_len_nxt;

    logic               w_idle;
    logic               w_len_ok;
    logic               w_xfer;
    logic               w_last;
    logic [2*FP8_W-1:0] w_rd_pair;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_len_ok = len_in_range(32'(i_len), 32'(DEPTH));
    // In STREAM the registered valid is always high, so ready alone decides
    assign w_xfer   = (r_state == ST_STREAM) && pe.i_pe_ready_for_new;
    assign w_last   = (r_idx == r_len - 1'b1);

    // Writes are only honoured while idle so a running stream never sees
    // its operands change underneath it.
    fp8_pair_buf #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_idle && i_wr_en),
        .i_waddr (i_wr_addr),
        .i_wdata ({i_wr_a, i_wr_b}),
        .i_raddr (w_idx_nxt[ADDR_W-1:0]),
        .o_rdata (w_rd_pair)
    );

    // State, pair index and latched length
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_len   <= w_len_nxt;
        end
    end

    // Next-state and index sequencing
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_len_nxt   = r_len;
        case (r_state)
            ST_IDLE: begin
                if (i_start && w_len_ok) begin
                    w_state_nxt = ST_CLEAR;
                    w_idx_nxt   = '0;
                    w_len_nxt   = i_len;
                end
            end
            ST_CLEAR: begin
                w_state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (w_xfer) begin
                    if (w_last) begin
                        w_state_nxt = ST_WAIT_DONE;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (pe.i_pe_mac_done) begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (i_result_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered outputs decoded from the upcoming state so every strobe
    // lines up with the state it belongs to.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            o_busy              <= 1'b0;
            o_cmd_err           <= 1'b0;
            pe.o_pe_clear_acc   <= 1'b0;
            pe.o_pe_data_valid  <= 1'b0;
            pe.o_pe_a           <= '0;
            pe.o_pe_b           <= '0;
            pe.o_pe_read_en     <= 1'b0;
            o_result_valid      <= 1'b0;
            o_result            <= '0;
        end else begin
            o_busy             <= (w_state_nxt != ST_IDLE);
            o_cmd_err          <= w_idle && i_start && !w_len_ok;
            pe.o_pe_clear_acc  <= (w_state_nxt == ST_CLEAR);
            pe.o_pe_data_valid <= (w_state_nxt == ST_STREAM);
            pe.o_pe_read_en    <= (w_state_nxt == ST_READ);
            o_result_valid     <= (w_state_nxt == ST_HOLD);
            if (w_state_nxt == ST_STREAM) begin
                pe.o_pe_a <= w_rd_pair[2*FP8_W-1:FP8_W];
                pe.o_pe_b <= w_rd_pair[FP8_W-1:0];
            end else begin
                pe.o_pe_a <= '0;
                pe.o_pe_b <= '0;
            end
            // Capture on the edge that ends the read-acknowledge cycle
            if (r_state == ST_READ) begin
                o_result <= pe.i_pe_c;
            end
        end
    end

endmodule

// File: tb/tb_fp8_pe_seq.sv
// Directed bench for fp8_pe_seq with a small PE model that counts
// transfers and raises mac_done once the expected count is reached.
module tb_fp8_pe_seq;
    import fp8_pkg::*;

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_wr_en;
    logic [3:0] i_wr_addr;
    logic [7:0] i_wr_a, i_wr_b;
    logic       i_start;
    logic [3:0] i_len;
    logic       o_busy, o_cmd_err;
    logic [7:0] o_result;
    logic       o_result_valid;
    logic       i_result_ready;

    int errors = 0;
    int checks = 0;
    int n_clear = 0, n_rd = 0, n_xfer = 0, n_err = 0;

    int   pe_target = 0;
    int   pe_cnt = 0;
    logic pe_fired = 1'b0;

    fp8_pe_seq_if pe_if();

    fp8_pe_seq #(.DEPTH(9)) dut (
        .clk            (clk),
        .i_reset        (i_reset),
        .i_wr_en        (i_wr_en),
        .i_wr_addr      (i_wr_addr),
        .i_wr_a         (i_wr_a),
        .i_wr_b         (i_wr_b),
        .i_start        (i_start),
        .i_len          (i_len),
        .o_busy         (o_busy),
        .o_cmd_err      (o_cmd_err),
        .pe             (pe_if.master),
        .o_result       (o_result),
        .o_result_valid (o_result_valid),
        .i_result_ready (i_result_ready)
    );

    always #5 clk = ~clk;

    // Strobe counters
    always @(posedge clk) begin
        if (pe_if.o_pe_clear_acc) n_clear <= n_clear + 1;
        if (pe_if.o_pe_read_en)   n_rd    <= n_rd + 1;
        if (pe_if.o_pe_data_valid && pe_if.i_pe_ready_for_new) n_xfer <= n_xfer + 1;
        if (o_cmd_err)            n_err   <= n_err + 1;
    end

    // PE model: mac_done one cycle after the last expected pair, held until read_en
    always @(posedge clk) begin
        if (i_reset || pe_if.o_pe_clear_acc) begin
            pe_cnt <= 0;
            pe_fired <= 1'b0;
            pe_if.i_pe_mac_done <= 1'b0;
        end else begin
            if (pe_if.o_pe_data_valid && pe_if.i_pe_ready_for_new) pe_cnt <= pe_cnt + 1;
            if (pe_if.i_pe_mac_done && pe_if.o_pe_read_en) begin
                pe_if.i_pe_mac_done <= 1'b0;
            end else if (!pe_fired && pe_target != 0 && pe_cnt == pe_target) begin
                pe_if.i_pe_mac_done <= 1'b1;
                pe_fired <= 1'b1;
            end
        end
    end

    task automatic write_slot(input logic [3:0] addr, input logic [7:0] a, input logic [7:0] b);
        i_wr_en = 1'b1; i_wr_addr = addr; i_wr_a = a; i_wr_b = b;
        @(negedge clk);
        i_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_busy, o_cmd_err, pe_if.o_pe_data_valid, pe_if.o_pe_clear_acc,
             pe_if.o_pe_read_en, o_result_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy=%b err=%b v=%b clr=%b rd=%b rv=%b, want all 0",
                     o_busy, o_cmd_err, pe_if.o_pe_data_valid, pe_if.o_pe_clear_acc,
                     pe_if.o_pe_read_en, o_result_valid);
        end
        checks++;
        if ({o_result, pe_if.o_pe_a, pe_if.o_pe_b} !== 24'h0) begin
            errors++;
            $display("FAIL reset_data: got res=%h a=%h b=%h, want 00 00 00",
                     o_result, pe_if.o_pe_a, pe_if.o_pe_b);
        end
        i_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_len9();
        int c0, r0;
        for (int i = 0; i < 9; i++) write_slot(4'(i), FP8_ONE, FP8_TWO);
        pe_target = 9; pe_if.i_pe_c = 8'h59;   // 9 * 1.0 * 2.0 = 18.0
        pe_if.i_pe_ready_for_new = 1'b1; i_result_ready = 1'b1;
        c0 = n_clear; r0 = n_rd;
        i_start = 1'b1; i_len = 4'd9;
        @(negedge clk);
        i_start = 1'b0;
        checks++;
        if ({o_busy, pe_if.o_pe_clear_acc, pe_if.o_pe_data_valid} !== 3'b110) begin
            errors++;
            $display("FAIL full_cyc1: got busy=%b clr=%b v=%b, want 1 1 0",
                     o_busy, pe_if.o_pe_clear_acc, pe_if.o_pe_data_valid);
        end
        for (int c = 2; c <= 10; c++) begin
            @(negedge clk);
            checks++;
            if ({pe_if.o_pe_data_valid, pe_if.o_pe_clear_acc, pe_if.o_pe_a, pe_if.o_pe_b} !== {2'b10, 8'h38, 8'h40}) begin
                errors++;
                $display("FAIL full_cyc%0d: got v=%b clr=%b a=%h b=%h, want 1 0 38 40",
                         c, pe_if.o_pe_data_valid, pe_if.o_pe_clear_acc, pe_if.o_pe_a, pe_if.o_pe_b);
            end
        end
        @(negedge clk);
        checks++;
        if (pe_if.o_pe_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_cyc11: got valid=%b, want 0", pe_if.o_pe_data_valid);
        end
        for (int i = 0; i < 20 && o_result_valid !== 1'b1; i++) @(negedge clk);
        checks++;
        if (o_result_valid !== 1'b1 || o_result !== 8'h59) begin
            errors++;
            $display("FAIL full_result: got rv=%b res=%h, want 1 59", o_result_valid, o_result);
        end
        @(negedge clk);
        checks++;
        if ({o_result_valid, o_busy} !== 2'b00) begin
            errors++;
            $display("FAIL full_release: got rv=%b busy=%b, want 0 0", o_result_valid, o_busy);
        end
        checks++;
        if (n_clear - c0 != 1 || n_rd - r0 != 1) begin
            errors++;
            $display("FAIL full_strobes: got clears=%0d reads=%0d, want 1 1", n_clear - c0, n_rd - r0);
        end
    endtask

    task automatic test_ready_toggle();
        int x0, exp_idx, k;
        logic [3:0] pat;
        logic seen;
        pat = 4'b1001;   // ready per valid cycle: 1,0,0,1,...
        for (int i = 0; i < 4; i++) write_slot(4'(i), 8'(8'h10 + i), 8'(8'h20 + i));
        pe_target = 4; pe_if.i_pe_c = 8'h44;
        x0 = n_xfer; exp_idx = 0; k = 0; seen = 1'b0;
        i_start = 1'b1; i_len = 4'd4;
        @(negedge clk);
        i_start = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (pe_if.o_pe_data_valid === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (exp_idx > 3 || pe_if.o_pe_a !== 8'(8'h10 + exp_idx) || pe_if.o_pe_b !== 8'(8'h20 + exp_idx)) begin
                    errors++;
                    $display("FAIL toggle_pair k=%0d: got a=%h b=%h, want a=%h b=%h (slot %0d)",
                             k, pe_if.o_pe_a, pe_if.o_pe_b, 8'(8'h10 + exp_idx), 8'(8'h20 + exp_idx), exp_idx);
                end
                pe_if.i_pe_ready_for_new = pat[k % 4];
                if (pat[k % 4]) exp_idx++;
                k++;
            end else if (seen) begin
                break;
            end
        end
        pe_if.i_pe_ready_for_new = 1'b1;
        checks++;
        if (exp_idx != 4 || n_xfer - x0 != 4) begin
            errors++;
            $display("FAIL toggle_count: got model=%0d observed=%0d transfers, want 4", exp_idx, n_xfer - x0);
        end
        for (int i = 0; i < 20 && o_result_valid !== 1'b1; i++) @(negedge clk);
        checks++;
        if (o_result_valid !== 1'b1 || o_result !== 8'h44) begin
            errors++;
            $display("FAIL toggle_result: got rv=%b res=%h, want 1 44", o_result_valid, o_result);
        end
        @(negedge clk);
    endtask

    task automatic test_cmd_err();
        int c0, e0;
        logic [3:0] bad [2];
        bad[0] = 4'd0; bad[1] = 4'd10;
        c0 = n_clear; e0 = n_err;
        for (int t = 0; t < 2; t++) begin
            i_start = 1'b1; i_len = bad[t];
            @(negedge clk);
            i_start = 1'b0;
            checks++;
            if ({o_cmd_err, o_busy} !== 2'b10) begin
                errors++;
                $display("FAIL cmd_err_len%0d: got err=%b busy=%b, want 1 0", bad[t], o_cmd_err, o_busy);
            end
            @(negedge clk);
            checks++;
            if ({o_cmd_err, o_busy, pe_if.o_pe_clear_acc} !== 3'b000) begin
                errors++;
                $display("FAIL cmd_err_after_len%0d: got err=%b busy=%b clr=%b, want 0 0 0",
                         bad[t], o_cmd_err, o_busy, pe_if.o_pe_clear_acc);
            end
        end
        checks++;
        if (n_clear != c0 || n_err - e0 != 2) begin
            errors++;
            $display("FAIL cmd_err_counts: got clears=%0d errs=%0d, want 0 2", n_clear - c0, n_err - e0);
        end
    endtask

    task automatic test_hold_stall();
        int c0;
        pe_target = 2; pe_if.i_pe_c = 8'h5a;
        pe_if.i_pe_ready_for_new = 1'b1; i_result_ready = 1'b0;
        c0 = n_clear;
        i_start = 1'b1; i_len = 4'd2;
        @(negedge clk);
        // busy: these must be ignored
        i_wr_en = 1'b1; i_wr_addr = 4'd1; i_wr_a = 8'hff; i_wr_b = 8'hff;
        i_start = 1'b1; i_len = 4'd1;
        @(negedge clk);
        i_wr_en = 1'b0; i_start = 1'b0;
        for (int i = 0; i < 20 && o_result_valid !== 1'b1; i++) @(negedge clk);
        for (int h = 0; h < 5; h++) begin
            checks++;
            if ({o_result_valid, o_busy, o_result} !== {2'b11, 8'h5a}) begin
                errors++;
                $display("FAIL hold_cyc%0d: got rv=%b busy=%b res=%h, want 1 1 5a", h, o_result_valid, o_busy, o_result);
            end
            i_start = (h == 2); i_len = 4'd2;
            @(negedge clk);
        end
        i_start = 1'b0;
        i_result_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_result_valid, o_busy} !== 2'b00 || n_clear - c0 != 1) begin
            errors++;
            $display("FAIL hold_release: got rv=%b busy=%b clears=%0d, want 0 0 1", o_result_valid, o_busy, n_clear - c0);
        end
        // Slot 1 must still hold the pair written before the busy write
        i_start = 1'b1; i_len = 4'd2;
        @(negedge clk);
        i_start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({pe_if.o_pe_data_valid, pe_if.o_pe_a, pe_if.o_pe_b} !== {1'b1, 8'h11, 8'h21}) begin
            errors++;
            $display("FAIL hold_buf_slot1: got v=%b a=%h b=%h, want 1 11 21",
                     pe_if.o_pe_data_valid, pe_if.o_pe_a, pe_if.o_pe_b);
        end
        for (int i = 0; i < 20 && o_result_valid !== 1'b1; i++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int c0;
        for (int i = 0; i < 9; i++) write_slot(4'(i), 8'(8'h30 + i), 8'(8'h40 + i));
        pe_target = 9; pe_if.i_pe_ready_for_new = 1'b1;
        i_start = 1'b1; i_len = 4'd9;
        @(negedge clk);
        i_start = 1'b0;
        repeat (2) @(negedge clk);           // transfers of slots 0 and 1
        @(negedge clk);
        pe_if.i_pe_ready_for_new = 1'b0;
        i_reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_busy, o_cmd_err, pe_if.o_pe_data_valid, pe_if.o_pe_clear_acc, pe_if.o_pe_read_en,
             o_result_valid, pe_if.o_pe_a, pe_if.o_pe_b} !== 22'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got busy=%b v=%b a=%h b=%h, want all 0",
                     o_busy, pe_if.o_pe_data_valid, pe_if.o_pe_a, pe_if.o_pe_b);
        end
        i_reset = 1'b0;
        pe_if.i_pe_ready_for_new = 1'b1;
        pe_target = 3; pe_if.i_pe_c = 8'h50;
        c0 = n_clear;
        i_start = 1'b1; i_len = 4'd3;
        @(negedge clk);
        i_start = 1'b0;
        checks++;
        if (pe_if.o_pe_clear_acc !== 1'b1) begin
            errors++;
            $display("FAIL midreset_clear: got clr=%b, want 1", pe_if.o_pe_clear_acc);
        end
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checks++;
            if ({pe_if.o_pe_data_valid, pe_if.o_pe_a, pe_if.o_pe_b} !== {1'b1, 8'(8'h30 + s), 8'(8'h40 + s)}) begin
                errors++;
                $display("FAIL midreset_slot%0d: got v=%b a=%h b=%h, want 1 %h %h",
                         s, pe_if.o_pe_data_valid, pe_if.o_pe_a, pe_if.o_pe_b, 8'(8'h30 + s), 8'(8'h40 + s));
            end
        end
        for (int i = 0; i < 20 && o_result_valid !== 1'b1; i++) @(negedge clk);
        checks++;
        if (o_result_valid !== 1'b1 || o_result !== 8'h50 || n_clear - c0 != 1) begin
            errors++;
            $display("FAIL midreset_result: got rv=%b res=%h clears=%0d, want 1 50 1",
                     o_result_valid, o_result, n_clear - c0);
        end
        @(negedge clk);
    endtask

    task automatic test_wr_start_same();
        pe_target = 1; pe_if.i_pe_c = 8'h40;   // 2.0 * 1.0
        i_wr_en = 1'b1; i_wr_addr = 4'd0; i_wr_a = FP8_TWO; i_wr_b = FP8_ONE;
        i_start = 1'b1; i_len = 4'd1;
        @(negedge clk);
        i_wr_en = 1'b0; i_start = 1'b0;
        @(negedge clk);
        checks++;
        if ({pe_if.o_pe_data_valid, pe_if.o_pe_a, pe_if.o_pe_b} !== {1'b1, 8'h40, 8'h38}) begin
            errors++;
            $display("FAIL same_cycle_pair: got v=%b a=%h b=%h, want 1 40 38",
                     pe_if.o_pe_data_valid, pe_if.o_pe_a, pe_if.o_pe_b);
        end
        @(negedge clk);
        checks++;
        if (pe_if.o_pe_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_len1: got valid=%b, want 0", pe_if.o_pe_data_valid);
        end
        for (int i = 0; i < 20 && o_result_valid !== 1'b1; i++) @(negedge clk);
        checks++;
        if (o_result_valid !== 1'b1 || o_result !== 8'h40) begin
            errors++;
            $display("FAIL same_cycle_result: got rv=%b res=%h, want 1 40", o_result_valid, o_result);
        end
        @(negedge clk);
    endtask

    initial begin
        i_reset = 1'b1; i_wr_en = 1'b0; i_wr_addr = '0; i_wr_a = '0; i_wr_b = '0;
        i_start = 1'b0; i_len = '0; i_result_ready = 1'b1;
        pe_if.i_pe_ready_for_new = 1'b1; pe_if.i_pe_c = '0;
        @(negedge clk);
        test_reset();
        test_full_len9();
        test_ready_toggle();
        test_cmd_err();
        test_hold_stall();
        test_reset_mid();
        test_wr_start_same();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
